// File: rtl/bin2bcd_pkg.sv
// ============================================================================
// Module  : bin2bcd_pkg
// Brief   : Shared state encoding, add-3 constants and sizing helper for bin2bcd_seq.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bin2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD       = 4'd3;

  // Decimal digits of 2^w-1: floor(w*log10(2))+1, exact because 2^w is never a power of ten.
  function automatic int digits_needed(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// Module  : bcd_digit_adj
// Brief   : One BCD nibble correction cell: adds 3 when the digit is 5 or more.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // 4-bit sum wraps modulo 16; no carry leaves the nibble.
  assign nib_o = (nib_i >= BCD_ADJ_THRESHOLD) ? (nib_i + BCD_ADJ_ADD) : nib_i;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Sequential double-dabble binary-to-BCD converter, start/busy/done handshake.
//           Optional macro LEADING_ZERO_BLANK_EN adds the registered 'blank' output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W      = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef LEADING_ZERO_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  state_t          state_q, state_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [SW-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   bcd_q, bcd_d;
  logic [SW-1:0]   w_adj;
  logic [SW+W-1:0] w_step;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .nib_i (scratch_q[4*gi +: 4]),
        .nib_o (w_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Adjust first, then shift the joint {scratch, binary} register left by one.
  assign w_step = {w_adj, bin_q} << 1;

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] w_blank;
  logic              w_zero_run;

  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (w_step[W + 4*i +: 4] == 4'd0);
      w_blank[i] = w_zero_run;
    end
  end

  assign blank = blank_q;
`endif

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
`ifdef LEADING_ZERO_BLANK_EN
    blank_d   = blank_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d   = ST_SHIFT;
          bin_d     = bin;
          scratch_d = '0;
          cnt_d     = CW'(W);
        end
      end
      ST_SHIFT: begin
        scratch_d = w_step[SW+W-1:W];
        bin_d     = w_step[W-1:0];
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          bcd_d   = w_step[SW+W-1:W];
`ifdef LEADING_ZERO_BLANK_EN
          blank_d = w_blank;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q   <= blank_d;
`endif
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign bcd  = bcd_q;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ============================================================================
// Module  : tb_bin2bcd_seq
// Brief   : Scoreboard bench for bin2bcd_seq (blank checks when LEADING_ZERO_BLANK_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bin2bcd_seq;

  localparam int W      = 32;
  localparam int DIGITS = 10;

  logic                clock   = 1'b0;
  logic                reset_n = 1'b0;
  logic                start   = 1'b0;
  logic [W-1:0]        bin     = '0;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]   blank;
`endif

  always #5 clock = ~clock;

  bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd)
`ifdef LEADING_ZERO_BLANK_EN
    ,
    .blank   (blank)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic [4*DIGITS-1:0] exp_q [$];
  logic [DIGITS-1:0]   expb_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [4*DIGITS-1:0] model_bcd(input longint unsigned v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] model_blank(input longint unsigned v);
    logic [DIGITS-1:0] r;
    int nd;
    longint unsigned t;
    r  = '0;
    nd = 1;
    t  = v / 10;
    while (t != 0) begin
      nd++;
      t = t / 10;
    end
    for (int i = 1; i < DIGITS; i++) if (i >= nd) r[i] = 1'b1;
    return r;
  endfunction

  always @(posedge clock) cyc++;

  // Scoreboard consumer: every done pulse pops and compares one expected result.
  always @(posedge clock) begin
    #1;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        chk("bcd", 64'(bcd), 64'(exp_q.pop_front()));
`ifdef LEADING_ZERO_BLANK_EN
        chk("blank", 64'(blank), 64'(expb_q.pop_front()));
`else
        void'(expb_q.pop_front());
`endif
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] v);
    exp_q.push_back(model_bcd(64'(v)));
    expb_q.push_back(model_blank(64'(v)));
  endtask

  task automatic convert(input logic [W-1:0] v, output int acc);
    @(negedge clock);
    start = 1'b1;
    bin   = v;
    push_exp(v);
    @(posedge clock);
    #1;
    acc = cyc;
    chk("busy_after_accept", 64'(busy), 64'd1);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output int at, output int busy_n);
    at     = -1;
    busy_n = 0;
    for (int k = 0; k < W + 8; k++) begin
      @(posedge clock);
      #1;
      if (done) begin
        at = cyc;
        break;
      end
      if (busy) busy_n++;
    end
    if (at < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, at, at1, bn, d0;
    logic [W-1:0] vals [3];
    vals[0] = 32'd4294967295;
    vals[1] = 32'd0;
    vals[2] = 32'd1050;

    repeat (2) @(posedge clock);
    #1;
    chk("reset_bcd", 64'(bcd), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Abort a conversion of 1234 with a two-cycle reset.
    @(negedge clock);
    start = 1'b1;
    bin   = 32'd1234;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("abort_bcd", 64'(bcd), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    d0 = done_cnt;
    repeat (W + 5) @(posedge clock);
    #1;
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

    // Single conversion: latency, busy length, held result.
    d0 = done_cnt;
    convert(32'd1234, acc);
    wait_done(at, bn);
    chk("latency_1234", 64'(at - acc), 64'(W));
    chk("busy_len_1234", 64'(bn + 1), 64'(W));
    repeat (6) @(negedge clock);
    chk("hold_1234", 64'(bcd), 64'h0000001234);
    chk("single_done_1234", 64'(done_cnt - d0), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);

    foreach (vals[i]) begin
      convert(vals[i], acc);
      wait_done(at, bn);
      chk("latency_vals", 64'(at - acc), 64'(W));
      repeat (2) @(negedge clock);
    end
    chk("hold_1050", 64'(bcd), 64'h0000001050);

    // start/bin during SHIFT must be ignored.
    d0 = done_cnt;
    convert(32'd5678, acc);
    repeat (9) @(negedge clock);
    start = 1'b1;
    bin   = 32'd99;
    @(negedge clock);
    start = 1'b0;
    bin   = 32'd0;
    wait_done(at, bn);
    chk("latency_5678", 64'(at - acc), 64'(W));
    repeat (W + 5) @(posedge clock);
    #1;
    chk("ignored_start_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("hold_5678", 64'(bcd), 64'h0000005678);

    // Back-to-back with start held high: 7 then 8.
    @(negedge clock);
    start = 1'b1;
    bin   = 32'd7;
    push_exp(32'd7);
    wait_done(at1, bn);
    chk("b2b_busy_in_done", 64'(busy), 64'd0);
    @(negedge clock);
    bin = 32'd8;
    push_exp(32'd8);
    wait_done(at, bn);
    @(negedge clock);
    start = 1'b0;
    chk("b2b_interval", 64'(at - at1), 64'(W + 1));
    chk("b2b_busy_len", 64'(bn), 64'(W));
    repeat (4) @(negedge clock);
    chk("b2b_hold_8", 64'(bcd), 64'h0000000008);
    chk("b2b_no_extra", 64'(busy), 64'd0);

    repeat (W + 5) @(posedge clock);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
